// File: rtl/divclk_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// The expected-period helper keeps the 2*D rule in one place.
package divclk_pkg;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int CW_DEF      = 10;
  localparam int LOCK_N_DEF  = 4;
  localparam int TIMEOUT_DEF = 600;
  localparam int ECW_DEF     = 8;

  function automatic logic [8:0] exp_period(input logic [7:0] d);
    return {d, 1'b0};
  endfunction

endpackage

// File: rtl/divclk_edge_det.sv
// Two-flop sampler for a clk-synchronous level, with single-cycle rise/fall pulses.
// Reusable by any monitor that watches a slow clock in the clk domain.
module divclk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= sig;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/divclk_monitor.sv
// Checks the divider output: measures period/high time per rising edge, compares
// against the divide setting, and reports lock, mismatch and stall conditions.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SEEK    | waiting for a clean rising edge; nothing is reported/checked
//   MEASURE | every rise reports the last period and checks it against D
module divclk_monitor
  import divclk_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int LOCK_N  = LOCK_N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ECW     = ECW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           clock_in,
  input  logic [7:0]     divide_in,
  output logic [CW-1:0]  period_out,
  output logic [CW-1:0]  high_out,
  output logic           meas_valid,
  output logic           locked,
  output logic           err,
  output logic           stall,
  output logic [ECW-1:0] err_count
);

  localparam logic [0:0]     ST_SEEK    = SEEK;
  localparam logic [0:0]     ST_MEASURE = MEASURE;
  localparam int             LW         = $clog2(LOCK_N + 1);
  localparam logic [LW-1:0]  LOCK_MAX   = LW'(LOCK_N);
  localparam logic [CW-1:0]  CNT_MAX    = '1;
  localparam logic [CW-1:0]  TO_VAL     = CW'(TIMEOUT);
  localparam logic [ECW-1:0] ERR_MAX    = '1;

  logic          c_q, rise, unused_fall;
  logic [0:0]    state;
  logic [7:0]    d_q;
  logic [CW-1:0] cnt, hi, exp_p, exp_h;
  logic [LW-1:0] lock_cnt;
  logic          disturb, check_en, mismatch, timeout_hit, err_set;

  divclk_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (clock_in),
    .level (c_q),
    .rise  (rise),
    .fall  (unused_fall)
  );

  always_comb begin
    exp_p       = CW'(exp_period(d_q));
    exp_h       = CW'(d_q);
    disturb     = (divide_in != d_q) || !enable;
    check_en    = (d_q != 8'd0);
    mismatch    = (cnt != exp_p) || (hi != exp_h);
    timeout_hit = (cnt == TO_VAL) && !rise && check_en;
    err_set     = 1'b0;
    if (!disturb) begin
      if (rise) err_set = (state == ST_MEASURE) && check_en && mismatch;
      else      err_set = timeout_hit;
    end
  end

  // Counters free-run in both states so the first MEASURE period starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
    end else if (rise) begin
      cnt <= CW'(1);
      hi  <= CW'(1);
    end else begin
      if (cnt != CNT_MAX)       cnt <= cnt + 1'b1;
      if (c_q && hi != CNT_MAX) hi  <= hi + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SEEK;
      d_q        <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      stall      <= 1'b0;
      err_count  <= '0;
      lock_cnt   <= '0;
    end else begin
      d_q        <= divide_in;
      meas_valid <= 1'b0;
      err        <= err_set;
      if (err_set && err_count != ERR_MAX) err_count <= err_count + 1'b1;
      if (rise) stall <= 1'b0;

      // A setting change or disable invalidates the period in flight.
      if (disturb) begin
        state    <= ST_SEEK;
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (rise) begin
        if (state == ST_SEEK) begin
          state <= ST_MEASURE;
        end else begin
          period_out <= cnt;
          high_out   <= hi;
          meas_valid <= 1'b1;
          if (!check_en || mismatch) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
          end else begin
            if (lock_cnt != LOCK_MAX)          lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt >= LOCK_MAX - 1'b1)   locked   <= 1'b1;
          end
        end
      end else if (timeout_hit) begin
        stall    <= 1'b1;
        locked   <= 1'b0;
        lock_cnt <= '0;
        state    <= ST_SEEK;
      end
    end
  end

endmodule

// File: tb/tb_divclk_monitor.sv
// Scoreboard bench for divclk_monitor: stimulus pushes expected measurements,
// a monitor pops and compares them whenever meas_valid is seen.
module tb_divclk_monitor;

  logic       clk = 1'b0;
  logic       rst, enable, clock_in;
  logic [7:0] divide_in;
  logic [9:0] period_out, high_out;
  logic       meas_valid, locked, err, stall;
  logic [7:0] err_count;

  typedef struct packed {
    logic [9:0] p;
    logic [9:0] h;
    logic       e;
    logic       l;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   tests = 0;
  int   fails = 0;
  int   err_pulses = 0;

  divclk_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clock_in   (clock_in),
    .divide_in  (divide_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .stall      (stall),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input int p, input int h, input int e, input int l, input int ec);
    exp_t x;
    x.p  = 10'(p);
    x.h  = 10'(h);
    x.e  = 1'(e);
    x.l  = 1'(l);
    x.ec = 8'(ec);
    sb.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int h);
    clock_in = 1'b1;
    cyc(h);
    clock_in = 1'b0;
    cyc(p - h);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_high"},   int'(high_out), 0);
    check({tag, "_mvalid"}, int'(meas_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"},    int'(err), 0);
    check({tag, "_stall"},  int'(stall), 0);
    check({tag, "_errcnt"}, int'(err_count), 0);
  endtask

  // Monitor: samples shortly after each active edge.
  always begin
    @(posedge clk);
    #2;
    if (err) err_pulses++;
    if (meas_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_meas: got period=%0d high=%0d, expected no measurement",
                 period_out, high_out);
      end else begin
        mon_x = sb.pop_front();
        check("meas_period", int'(period_out), int'(mon_x.p));
        check("meas_high",   int'(high_out),   int'(mon_x.h));
        check("meas_err",    int'(err),        int'(mon_x.e));
        check("meas_locked", int'(locked),     int'(mon_x.l));
        check("meas_errcnt", int'(err_count),  int'(mon_x.ec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int ep0;
    rst = 1'b1; enable = 1'b1; clock_in = 1'b0; divide_in = 8'd3;
    @(negedge clk);
    cyc(5);
    check_all_zero("reset");
    rst = 1'b0;
    cyc(3);

    // Scenario 1: D=3, 6/3 clock, lock on 4th checked period
    push(6,3,0,0,0); push(6,3,0,0,0); push(6,3,0,0,0);
    push(6,3,0,1,0); push(6,3,0,1,0);
    repeat (6) drive_period(6, 3);

    // Scenario 2: one 7/4 period breaks lock, relock after 4 good
    push(6,3,0,1,0);
    push(7,4,1,0,1);
    push(6,3,0,0,1); push(6,3,0,0,1); push(6,3,0,0,1); push(6,3,0,1,1);
    drive_period(7, 4);
    repeat (5) drive_period(6, 3);

    // Scenario 3: divide 3->5 mid-period, no err, relock at 10/5
    push(6,3,0,1,1);
    clock_in = 1'b1;
    cyc(2);
    check("pre_change_locked", int'(locked), 1);
    divide_in = 8'd5;
    cyc(1);
    check("change_locked_drop", int'(locked), 0);
    check("change_no_err", int'(err), 0);
    cyc(2);
    clock_in = 1'b0;
    cyc(5);
    push(10,5,0,0,1); push(10,5,0,0,1); push(10,5,0,0,1); push(10,5,0,1,1);
    repeat (5) drive_period(10, 5);

    // Scenario 4: D=4, clock held low until stall
    ep0 = err_pulses;
    divide_in = 8'd4;
    waited = 0;
    while (!stall && waited < 700) begin
      cyc(1);
      waited++;
    end
    check("stall_latency", waited, 592);
    cyc(20);
    check("stall_sticky", int'(stall), 1);
    check("stall_single_err", err_pulses - ep0, 1);
    check("stall_errcnt", int'(err_count), 2);
    check("stall_locked", int'(locked), 0);
    push(8,4,0,0,2); push(8,4,0,0,2); push(8,4,0,0,2);
    push(8,4,0,1,2); push(8,4,0,1,2);
    clock_in = 1'b1;
    cyc(2);
    check("stall_clear", int'(stall), 0);
    cyc(2);
    clock_in = 1'b0;
    cyc(4);
    repeat (5) drive_period(8, 4);

    // Scenario 5: D=0 bypass, measurements only
    ep0 = err_pulses;
    divide_in = 8'd0;
    cyc(2);
    push(5,2,0,0,2); push(9,7,0,0,2); push(4,1,0,0,2);
    drive_period(5, 2);
    drive_period(9, 7);
    drive_period(4, 1);
    drive_period(3, 1);
    check("bypass_no_err", err_pulses - ep0, 0);

    // Scenario 6: lock, one bad period, relock, then reset mid-MEASURE
    divide_in = 8'd3;
    push(6,3,0,0,2); push(6,3,0,0,2); push(6,3,0,0,2); push(6,3,0,1,2);
    push(6,3,0,1,2);
    push(5,2,1,0,3);
    push(6,3,0,0,3); push(6,3,0,0,3); push(6,3,0,0,3); push(6,3,0,1,3);
    push(6,3,0,1,3);
    repeat (5) drive_period(6, 3);
    drive_period(5, 2);
    repeat (5) drive_period(6, 3);
    clock_in = 1'b1;
    cyc(3);
    check("prereset_locked", int'(locked), 1);
    check("prereset_errcnt", int'(err_count), 3);
    rst = 1'b1;
    clock_in = 1'b0;
    cyc(1);
    check_all_zero("midrst");
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // Restart behaves like scenario 1
    push(6,3,0,0,0); push(6,3,0,0,0); push(6,3,0,0,0);
    push(6,3,0,1,0); push(6,3,0,1,0); push(6,3,0,1,0);
    repeat (6) drive_period(6, 3);
    clock_in = 1'b1;
    cyc(3);
    clock_in = 1'b0;
    cyc(5);

    check("sb_drained", sb.size(), 0);
    check("total_err_pulses", err_pulses, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
